// File: rtl/aes_key_expand.sv
// AES-128 key schedule, one round key per valid/ready handshake.
// The key register holds the round key currently presented on rk_out; the
// next round key is formed combinationally from it and loaded on acceptance.
// rk_valid/rk_ready handshake: a key transfers in any cycle where both are
// high; while rk_valid=1 and rk_ready=0, rk_out and rk_idx hold stable.

// One AES S-box byte substitution, computed as GF(2^8) inverse + affine map.
module sbox_LUT (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);
    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Inverse as x^254 (so 0 maps to 0), then the affine transform with 0x63
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]}   ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign o_out = sbox_calc(i_in);
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t       r_state;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot;
    logic [7:0]   w_sub0, w_sub1, w_sub2, w_sub3;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [7:0]   w_rcon;
    logic         w_hs;

    assign w_w0  = r_key[127:96];
    assign w_w1  = r_key[95:64];
    assign w_w2  = r_key[63:32];
    assign w_w3  = r_key[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    sbox_LUT u_sbox0 (.i_in(w_rot[31:24]), .o_out(w_sub0));
    sbox_LUT u_sbox1 (.i_in(w_rot[23:16]), .o_out(w_sub1));
    sbox_LUT u_sbox2 (.i_in(w_rot[15:8]),  .o_out(w_sub2));
    sbox_LUT u_sbox3 (.i_in(w_rot[7:0]),   .o_out(w_sub3));

    // Round constant for the key about to be produced (round rk_idx+1)
    always_comb begin
        w_rcon = 8'h00;
        case (r_idx)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_t  = {w_sub0, w_sub1, w_sub2, w_sub3} ^ {w_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;
    assign w_hs = r_valid & rk_ready;

    // Control FSM with registered outputs; key/index advance only on a handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_key   <= key_in;
                        r_idx   <= 4'd0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        if (r_idx == 4'd10) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_key <= {w_n0, w_n1, w_n2, w_n3};
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign rk_out    = r_key;
    assign rk_idx    = r_idx;
    assign rk_valid  = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 word-by-word key expansion as reference.
module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   sbox_tab [0:255];
    logic [127:0] got_rk [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // Clock and DUT
    always #5 clk = ~clk;

    aes_key_expand dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // Reference model
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] y;
        r = 8'h00;
        x = a;
        y = b;
        while (y != 8'h00) begin
            if (y[0]) r = r ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    task automatic build_exp(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        exp_q.delete();
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
                    ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_q.push_back({w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]});
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        step();
        start  = 1'b0;
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // From the current RUN cycle, accept every key through idx 10, then FIN and IDLE
    task automatic drain_ready(input int from_idx);
        for (int i = from_idx; i <= 10; i++) begin
            rk_ready = 1'b1;
            n_vec++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_idx !== 4'(i) || rk_out !== exp_q[i]) begin
                n_err++;
                $display("FAIL drain_key: valid=%b busy=%b idx=%0d key=%h, expected valid=1 busy=1 idx=%0d key=%h",
                         rk_valid, busy, rk_idx, rk_out, i, exp_q[i]);
            end
            got_rk[i] = rk_out;
            step();
        end
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b1 || rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fin_cycle: done=%b busy=%b valid=%b, expected done=1 busy=1 valid=0",
                     done, busy, rk_valid);
        end
        step();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0 || rk_idx !== 4'd10 || rk_out !== exp_q[10]) begin
            n_err++;
            $display("FAIL idle_after_fin: done=%b busy=%b valid=%b idx=%0d key=%h, expected 0 0 0 10 %h",
                     done, busy, rk_valid, rk_idx, rk_out, exp_q[10]);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        rk_ready = 1'b0;
        key_in   = FIPS_KEY;
        repeat (3) step();
        n_vec++;
        if (rk_out !== 128'h0 || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: key=%h idx=%0d valid=%b busy=%b done=%b, expected all zero",
                     rk_out, rk_idx, rk_valid, busy, done);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        n_vec++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_start: valid=%b busy=%b done=%b, expected 0 0 0", rk_valid, busy, done);
        end
    endtask

    task automatic test_fips();
        build_exp(FIPS_KEY);
        do_start(FIPS_KEY);
        drain_ready(0);
        n_vec++;
        if (got_rk[0] !== FIPS_KEY || got_rk[1] !== FIPS_RK1 || got_rk[10] !== FIPS_RK10) begin
            n_err++;
            $display("FAIL fips_vectors: rk0=%h rk1=%h rk10=%h, expected %h %h %h",
                     got_rk[0], got_rk[1], got_rk[10], FIPS_KEY, FIPS_RK1, FIPS_RK10);
        end
    endtask

    task automatic test_zero_key();
        build_exp(128'h0);
        do_start(128'h0);
        drain_ready(0);
        n_vec++;
        if (got_rk[1] !== ZERO_RK1 || got_rk[10] !== ZERO_RK10) begin
            n_err++;
            $display("FAIL zero_vectors: rk1=%h rk10=%h, expected %h %h",
                     got_rk[1], got_rk[10], ZERO_RK1, ZERO_RK10);
        end
    endtask

    task automatic test_backpressure();
        build_exp(FIPS_KEY);
        do_start(FIPS_KEY);
        for (int i = 0; i < 3; i++) begin
            rk_ready = 1'b1;
            step();
        end
        rk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'd3 || rk_out !== exp_q[3]) begin
                n_err++;
                $display("FAIL backpressure_hold: cycle %0d valid=%b idx=%0d key=%h, expected 1 3 %h",
                         c, rk_valid, rk_idx, rk_out, exp_q[3]);
            end
            step();
        end
        drain_ready(3);
    endtask

    task automatic test_random_ready();
        logic [127:0] k;
        logic         r;
        int           got;
        bit           seen_done;
        for (int trial = 0; trial < 4; trial++) begin
            k = (trial == 0) ? FIPS_KEY : {$urandom(), $urandom(), $urandom(), $urandom()};
            build_exp(k);
            do_start(k);
            got = 0;
            seen_done = 1'b0;
            for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
                r = 1'($urandom_range(0, 1));
                rk_ready = r;
                if (done === 1'b1) begin
                    seen_done = 1'b1;
                end else begin
                    n_vec++;
                    if (rk_valid !== 1'b1 || got > 10 || rk_idx !== 4'(got) || rk_out !== exp_q[got]) begin
                        n_err++;
                        $display("FAIL random_ready: trial %0d valid=%b idx=%0d key=%h, expected valid=1 idx=%0d",
                                 trial, rk_valid, rk_idx, rk_out, got);
                    end
                    if (r) got++;
                    step();
                end
            end
            n_vec++;
            if (!seen_done || got != 11) begin
                n_err++;
                $display("FAIL random_count: trial %0d done_seen=%0d accepted=%0d, expected 1 11",
                         trial, seen_done, got);
            end
            step();
        end
        rk_ready = 1'b1;
    endtask

    task automatic test_start_ignored();
        logic [127:0] key_a;
        logic [127:0] key_b;
        key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_b = ~key_a;
        build_exp(key_a);
        do_start(key_a);
        for (int i = 0; i <= 10; i++) begin
            rk_ready = 1'b1;
            start    = (i == 4);
            key_in   = (i == 4) ? key_b : key_a;
            n_vec++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_idx !== 4'(i) || rk_out !== exp_q[i]) begin
                n_err++;
                $display("FAIL start_in_run: valid=%b busy=%b idx=%0d key=%h, expected 1 1 %0d %h",
                         rk_valid, busy, rk_idx, rk_out, i, exp_q[i]);
            end
            step();
        end
        start  = 1'b1;
        key_in = key_b;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b1 || rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_fin: done=%b busy=%b valid=%b, expected 1 1 0", done, busy, rk_valid);
        end
        step();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_idx !== 4'd10 || rk_out !== exp_q[10]) begin
            n_err++;
            $display("FAIL fin_start_dropped: busy=%b valid=%b idx=%0d key=%h, expected 0 0 10 %h",
                     busy, rk_valid, rk_idx, rk_out, exp_q[10]);
        end
        step();
        n_vec++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stays_idle: busy=%b valid=%b, expected 0 0", busy, rk_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] key_b;
        build_exp(FIPS_KEY);
        do_start(FIPS_KEY);
        for (int i = 0; i < 6; i++) begin
            rk_ready = 1'b1;
            step();
        end
        n_vec++;
        if (rk_idx !== 4'd6 || rk_out !== exp_q[6]) begin
            n_err++;
            $display("FAIL pre_reset_idx: idx=%0d key=%h, expected 6 %h", rk_idx, rk_out, exp_q[6]);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_vec++;
        if (rk_out !== 128'h0 || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: key=%h idx=%0d valid=%b busy=%b done=%b, expected all zero",
                     rk_out, rk_idx, rk_valid, busy, done);
        end
        step();
        key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        build_exp(key_b);
        do_start(key_b);
        drain_ready(0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] key_b;
        build_exp(FIPS_KEY);
        do_start(FIPS_KEY);
        drain_ready(0);
        key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        build_exp(key_b);
        do_start(key_b);
        drain_ready(0);
    endtask

    // Sequencer and final report
    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_backpressure();
        test_random_ready();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
